// File: rtl/uart_sync_fifo_pkg.sv
// uart_fifo_pkg: shared helpers and the FIFO status record used by the FIFO
// and by the UART status registers.
//   ptr_w(depth)   pointer width for a power-of-two depth
//   is_pow2(n)     true when n is a power of two and >= 2
//   fifo_status_t  empty/full/almost_empty/almost_full/overflow/underflow
package uart_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/uart_sync_fifo_if.sv
// uart_sync_fifo_if: host-side bundle of the UART FIFO.
//   master : drives wr_en/wr_data/rd_en/clr_err, observes data and status
//   slave  : the FIFO itself
//   Signals: wr_en, wr_data[WIDTH], rd_en, rd_data[WIDTH], rd_valid,
//            count[ptr_w(DEPTH)+1], empty, full, almost_empty, almost_full,
//            overflow, underflow, clr_err
interface uart_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    import uart_fifo_pkg::*;

    localparam int CW = ptr_w(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: simple dual-port storage, one synchronous write port and one
// asynchronous read port. No reset; contents are undefined until written.
//   clk    clock
//   we     write enable, waddr/wdata written on the rising edge
//   raddr  read address, rdata follows it combinationally
module uart_fifo_ram
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO between the UART datapath and the host.
//   clk, reset   clock and synchronous active-high reset
//   bus          uart_sync_fifo_if.slave (write/read handshake, fill count,
//                thresholds, sticky overflow/underflow, clr_err)
// Build option: define UART_FIFO_FWFT_EN for first-word-fall-through, where
// rd_data always shows the head and rd_valid = !empty. Otherwise rd_data is
// registered on an accepted read and rd_valid pulses the following cycle.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic clk,
    input  logic reset,
    uart_sync_fifo_if.slave bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             ovf, unf;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_q;
    fifo_status_t     status;

    // Flags come from the registered count, so they settle one cycle after
    // the access. A write while full is refused even if a read is popping.
    always_comb begin
        status              = '0;
        status.empty        = (count == '0);
        status.full         = (count == FULL_LVL);
        status.almost_empty = (count <= AE_LVL);
        status.almost_full  = (count >= AF_LVL);
        status.overflow     = ovf;
        status.underflow    = unf;
    end

    assign wr_acc = bus.wr_en && !status.full;
    assign rd_acc = bus.rd_en && !status.empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            if (bus.wr_en && status.full) ovf <= 1'b1;
            else if (bus.clr_err)         ovf <= 1'b0;
            if (bus.rd_en && status.empty) unf <= 1'b1;
            else if (bus.clr_err)          unf <= 1'b0;
        end
    end

    uart_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (bus.wr_data),
        .raddr (rptr),
        .rdata (ram_q)
    );

`ifdef UART_FIFO_FWFT_EN
    assign bus.rd_data  = ram_q;
    assign bus.rd_valid = !status.empty;
`else
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= ram_q;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.count        = count;
    assign bus.empty        = status.empty;
    assign bus.full         = status.full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.overflow     = status.overflow;
    assign bus.underflow    = status.underflow;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo, DEPTH=4, WIDTH=8, both margins 1.
// Covers standard mode by default and FWFT when UART_FIFO_FWFT_EN is defined.
module tb_uart_sync_fifo;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_sync_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    uart_sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        bus.wr_en = w; bus.wr_data = d; bus.rd_en = r; bus.clr_err = c;
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        reset = 1'b0;
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b want 1", bus.almost_empty); end
        n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", bus.almost_full); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {bus.overflow, bus.underflow}); end
`ifndef UART_FIFO_FWFT_EN
        n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
`endif
    endtask

    task automatic test_write_fill;
        logic [7:0] v [4];
        logic [2:0] exp_cnt [4];
        logic       exp_af  [4];
        logic       exp_ae  [4];
        logic       exp_ful [4];
        v       = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_af  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_ae  = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_ful = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cyc(1, v[i], 0, 0);
            n_checks++; if (bus.count !== exp_cnt[i]) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, exp_cnt[i]); end
            n_checks++; if (bus.almost_full !== exp_af[i]) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.almost_full, exp_af[i]); end
            n_checks++; if (bus.almost_empty !== exp_ae[i]) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b want %b", i, bus.almost_empty, exp_ae[i]); end
            n_checks++; if (bus.full !== exp_ful[i]) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, exp_ful[i]); end
        end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: got %b want 0", bus.overflow); end
        cyc(1, 8'hEE, 0, 0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", bus.count); end
    endtask

    task automatic test_read_drain;
        logic [7:0] v [4];
        logic [2:0] exp_cnt [4];
        v       = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 4; i++) begin
`ifdef UART_FIFO_FWFT_EN
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.rd_valid); end
            n_checks++; if (bus.rd_data !== v[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.rd_data, v[i]); end
            cyc(0, 8'h00, 1, 0);
`else
            cyc(0, 8'h00, 1, 0);
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.rd_valid); end
            n_checks++; if (bus.rd_data !== v[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.rd_data, v[i]); end
`endif
            n_checks++; if (bus.count !== exp_cnt[i]) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count, exp_cnt[i]); end
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
        cyc(0, 8'h00, 0, 0);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL pre_unf: got %b want 0", bus.underflow); end
        cyc(0, 8'h00, 1, 0);
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set: got %b want 1", bus.underflow); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL unf_valid: got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL unf_count: got %0d want 0", bus.count); end
    endtask

    // Two entries in flight, six simultaneous write/read pairs, then drain;
    // the pointers cross the 3 -> 0 boundary along the way.
    task automatic test_wrap;
        logic [7:0] e;
        cyc(1, 8'h10, 0, 0);
        cyc(1, 8'h11, 0, 0);
        for (int i = 0; i < 8; i++) begin
            e = 8'h10 + 8'(i);
`ifdef UART_FIFO_FWFT_EN
            n_checks++; if (bus.rd_data !== e) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.rd_data, e); end
            cyc((i < 6), 8'h12 + 8'(i), 1, 0);
`else
            cyc((i < 6), 8'h12 + 8'(i), 1, 0);
            n_checks++; if (bus.rd_data !== e || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h/%b want %h/1", i, bus.rd_data, bus.rd_valid, e); end
`endif
            if (i < 6) begin
                n_checks++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 2", i, bus.count); end
            end
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_clr_err;
        cyc(0, 8'h00, 0, 1);
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", bus.overflow); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL clr_unf: got %b want 0", bus.underflow); end
    endtask

    // Full with write+read: the read pops, the write is refused, so the
    // level drops to 3 and 0x99 must never come out.
    task automatic test_full_rdwr;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL frw_full: got %b want 1", bus.full); end
`ifdef UART_FIFO_FWFT_EN
        n_checks++; if (bus.rd_data !== 8'h20) begin n_fail++; $display("FAIL frw_head: got %h want 20", bus.rd_data); end
`endif
        cyc(1, 8'h99, 1, 0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL frw_ovf: got %b want 1", bus.overflow); end
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL frw_count: got %0d want 3", bus.count); end
`ifndef UART_FIFO_FWFT_EN
        n_checks++; if (bus.rd_data !== 8'h20 || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL frw_head: got %h/%b want 20/1", bus.rd_data, bus.rd_valid); end
`endif
        for (int i = 1; i < 4; i++) begin
            e = 8'h20 + 8'(i);
`ifdef UART_FIFO_FWFT_EN
            n_checks++; if (bus.rd_data !== e) begin n_fail++; $display("FAIL frw_drain[%0d]: got %h want %h", i, bus.rd_data, e); end
            cyc(0, 8'h00, 1, 0);
`else
            cyc(0, 8'h00, 1, 0);
            n_checks++; if (bus.rd_data !== e) begin n_fail++; $display("FAIL frw_drain[%0d]: got %h want %h", i, bus.rd_data, e); end
`endif
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL frw_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_empty_rdwr;
        cyc(1, 8'h77, 1, 0);
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL erw_count: got %0d want 1", bus.count); end
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL erw_unf: got %b want 1", bus.underflow); end
`ifdef UART_FIFO_FWFT_EN
        n_checks++; if (bus.rd_data !== 8'h77 || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL erw_data: got %h/%b want 77/1", bus.rd_data, bus.rd_valid); end
        cyc(0, 8'h00, 1, 0);
`else
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL erw_valid: got %b want 0", bus.rd_valid); end
        cyc(0, 8'h00, 1, 0);
        n_checks++; if (bus.rd_data !== 8'h77 || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL erw_data: got %h/%b want 77/1", bus.rd_data, bus.rd_valid); end
`endif
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL erw_count2: got %0d want 0", bus.count); end
    endtask

    // clr_err in the same cycle as a fresh overflow: overflow stays set,
    // the older underflow is cleared.
    task automatic test_clr_collision;
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0);
        n_checks++; if ({bus.overflow, bus.underflow} !== 2'b01) begin n_fail++; $display("FAIL coll_pre: got %b want 01", {bus.overflow, bus.underflow}); end
        for (int i = 0; i < 4; i++) cyc(1, 8'h30 + 8'(i), 0, 0);
        cyc(1, 8'hEE, 0, 1);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL coll_ovf: got %b want 1", bus.overflow); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL coll_unf: got %b want 0", bus.underflow); end
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL coll_count: got %0d want 4", bus.count); end
    endtask

    task automatic test_mid_reset;
        cyc(0, 8'h00, 1, 0);
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL mr_count3: got %0d want 3", bus.count); end
`ifndef UART_FIFO_FWFT_EN
        n_checks++; if (bus.rd_data !== 8'h30 || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pop: got %h/%b want 30/1", bus.rd_data, bus.rd_valid); end
`endif
        reset = 1'b1;
        cyc(0, 8'h00, 0, 0);
        reset = 1'b0;
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL mr_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mr_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL mr_ovf: got %b want 0", bus.overflow); end
        cyc(1, 8'h5A, 0, 0);
`ifndef UART_FIFO_FWFT_EN
        cyc(0, 8'h00, 1, 0);
`endif
        n_checks++; if (bus.rd_data !== 8'h5A || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL mr_5a: got %h/%b want 5a/1", bus.rd_data, bus.rd_valid); end
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        test_reset;
        test_write_fill;
        test_read_drain;
        test_wrap;
        test_clr_err;
        test_full_rdwr;
        test_empty_rdwr;
        test_clr_collision;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
